move_dispatcher: RTL
====================

Name: move_dispatcher

Overview:
- Front-end stage of the board validator. Accepts one move request over a valid/ready handshake and looks up the moving piece on the board.
- Computes the absolute deltas and runs the piece-independent legality pre-checks.
- Starts the piece-specific shape checker (knight, bishop, …) and collects its result. Returns a single registered legal/illegal response with a reason code.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles for checker_done before a TIMEOUT response.
- TCNT_W, 7: width of the timeout counter; must satisfy 2**TCNT_W > TIMEOUT_CYCLES.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  move request present.
- req_ready  out  1  block can accept a request.
- req_old_x, req_old_y  in  3 each  source square.
- req_new_x, req_new_y  in  3 each  destination square.
- side_to_move  in  1  0 = white, 1 = black.
- board_in  in  4 x [8][8]  piece codes indexed [y][x]; must stay stable from accept until the response handshake.
- chk_start  out  1  one-cycle start pulse to the selected checker.
- chk_piece_type  out  4  registered piece code of the moving piece.
- chk_old_x, chk_old_y, chk_new_x, chk_new_y  out  3 each  registered coordinates.
- chk_h_delta, chk_v_delta  out  3 each  |new_x-old_x|, |new_y-old_y|.
- chk_done  in  1  selected checker finished.
- chk_move_valid  in  1  checker verdict; sampled only when chk_done=1.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_legal  out  1  move legal.
- rsp_code  out  3  reason code, see package.

Behaviour:
- Piece encoding: 0 = empty; bit3 = colour (0 white, 1 black); bits[2:0] = kind (1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king). Kinds 0 and 7 with a nonzero code are invalid.
- Reset values: state IDLE; req_ready=1; rsp_valid=0, rsp_legal=0, rsp_code=0; chk_start=0; all chk_* data registers 0; timeout counter 0.
- FSM states: IDLE, PRECHECK, DISPATCH, WAIT, RESPOND.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch the four coordinates and side_to_move, then go to PRECHECK.
- PRECHECK (1 cycle):
  - Register piece=board_in[old_y][old_x], dst=board_in[new_y][new_x], and both absolute deltas. Deltas use a 4-bit signed difference truncated to 3 bits.
  - Evaluate pre-checks in this precedence order:
    - NULL_MOVE: old==new.
    - EMPTY_SRC: piece==0.
    - BAD_PIECE: kind is 0 or 7.
    - WRONG_SIDE: piece colour != side_to_move.
    - SELF_CAPTURE: dst!=0 and dst colour==piece colour.
  - On any failure, load rsp_legal=0 and that code, then go to RESPOND. Otherwise go to DISPATCH.
- DISPATCH (1 cycle):
  - chk_start=1; clear the timeout counter; go to WAIT.
  - chk_* data outputs hold constant from PRECHECK until the next accept.
- WAIT:
  - If chk_done: rsp_legal=chk_move_valid; rsp_code = OK if chk_move_valid, else ILLEGAL_SHAPE; go to RESPOND.
  - Else if counter==TIMEOUT_CYCLES-1: rsp_legal=0, rsp_code=TIMEOUT; go to RESPOND.
  - Else increment the counter.
  - If chk_done and the timeout coincide, chk_done wins.
- RESPOND:
  - rsp_valid=1; rsp_legal and rsp_code are held stable.
  - On rsp_ready, go to IDLE. req_ready rises the following cycle (no back-to-back accept in the same cycle).
- Latency, with accept at edge 0:
  - Pre-check failure: rsp_valid high after edge 2.
  - Checker path: chk_start high during cycle 2. With chk_done sampled at edge n (n≥3), rsp_valid is high after edge n.
- req_ready=0 in every state other than IDLE. req_valid is ignored there.
- Asynchronous reset mid-operation returns all outputs to reset values within that reset. No response is produced for the aborted request.

Decomposition:
- Package chess_pkg holds:
  - piece-code constants (PIECE_EMPTY, KIND_PAWN..KIND_KING, COLOR_BIT);
  - typedef rsp_code_t, logic [2:0]: OK=0, ILLEGAL_SHAPE=1, NULL_MOVE=2, EMPTY_SRC=3, BAD_PIECE=4, WRONG_SIDE=5, SELF_CAPTURE=6, TIMEOUT=7;
  - the dispatcher state enum.
- One natural sub-module, move_precheck: purely combinational pre-check and delta logic, instantiated by the FSM.

Test Plan:
- White knight 0x2 at (1,0), side_to_move=0, move to (2,2), checker model returns chk_done+valid 2 cycles after chk_start -> chk_h_delta=1, chk_v_delta=2; rsp_legal=1, rsp_code=0.
- Empty source (3,3)->(4,4) -> no chk_start pulse; rsp_valid after edge 2; rsp_legal=0, rsp_code=3.
- Black rook 0xC at (0,7) to (0,6) occupied by 0x9, side_to_move=1 -> rsp_code=6 (SELF_CAPTURE). Same move with side_to_move=0 -> rsp_code=5 (WRONG_SIDE).
- Checker never asserts done -> rsp_code=7 exactly TIMEOUT_CYCLES cycles after entering WAIT; done asserted on the final WAIT cycle -> normal verdict, not TIMEOUT.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_legal/rsp_code stable, req_ready=0, a new req_valid is not accepted. On release, req_ready returns 1 one cycle later.
- Assert reset_n low during WAIT -> all outputs at reset values immediately. Next request after reset completes normally.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared definitions for the board validator front end.
//   - Piece encoding: 0 = empty, bit3 = colour (0 white, 1 black),
//     bits[2:0] = kind (1 pawn .. 6 king); kinds 0 and 7 are invalid
//     whenever the code itself is nonzero.
//   - rsp_code_t: reason code returned with every move verdict.
//   - disp_state_t: state encoding of the move dispatcher FSM.
package chess_pkg;

  localparam logic [3:0]  PIECE_EMPTY  = 4'h0;
  localparam int unsigned COLOR_BIT    = 3;

  localparam logic [2:0]  KIND_NONE    = 3'd0;
  localparam logic [2:0]  KIND_PAWN    = 3'd1;
  localparam logic [2:0]  KIND_KNIGHT  = 3'd2;
  localparam logic [2:0]  KIND_BISHOP  = 3'd3;
  localparam logic [2:0]  KIND_ROOK    = 3'd4;
  localparam logic [2:0]  KIND_QUEEN   = 3'd5;
  localparam logic [2:0]  KIND_KING    = 3'd6;
  localparam logic [2:0]  KIND_INVALID = 3'd7;

  typedef enum logic [2:0] {
    OK            = 3'd0,
    ILLEGAL_SHAPE = 3'd1,
    NULL_MOVE     = 3'd2,
    EMPTY_SRC     = 3'd3,
    BAD_PIECE     = 3'd4,
    WRONG_SIDE    = 3'd5,
    SELF_CAPTURE  = 3'd6,
    TIMEOUT       = 3'd7
  } rsp_code_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRECHECK = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RESPOND  = 3'd4
  } disp_state_t;

  function automatic logic [2:0] piece_kind(input logic [3:0] code);
    return code[2:0];
  endfunction

  function automatic logic piece_color(input logic [3:0] code);
    return code[COLOR_BIT];
  endfunction

endpackage

// File: rtl/move_precheck.sv
// Piece-independent legality pre-checks for one move (purely combinational).
// Ports:
//   board_in      piece codes indexed [y][x]
//   old_x/old_y   source square
//   new_x/new_y   destination square
//   side_to_move  0 = white, 1 = black
//   piece         code on the source square
//   h_delta       |new_x - old_x|
//   v_delta       |new_y - old_y|
//   fail          some pre-check rejected the move
//   fail_code     reason of the highest-precedence failing check
module move_precheck import chess_pkg::*; (
  input  logic [7:0][7:0][3:0] board_in,
  input  logic [2:0]           old_x,
  input  logic [2:0]           old_y,
  input  logic [2:0]           new_x,
  input  logic [2:0]           new_y,
  input  logic                 side_to_move,
  output logic [3:0]           piece,
  output logic [2:0]           h_delta,
  output logic [2:0]           v_delta,
  output logic                 fail,
  output rsp_code_t            fail_code
);

  logic [3:0] dst;

  // Coordinates are widened to a 4-bit signed difference so the magnitude
  // of any on-board distance (0..7) survives truncation back to 3 bits.
  function automatic logic [2:0] abs_delta(input logic [2:0] from_c,
                                           input logic [2:0] to_c);
    logic signed [3:0] diff;
    diff = signed'({1'b0, to_c}) - signed'({1'b0, from_c});
    if (diff < 0) diff = -diff;
    return diff[2:0];
  endfunction

  assign piece   = board_in[old_y][old_x];
  assign dst     = board_in[new_y][new_x];
  assign h_delta = abs_delta(old_x, new_x);
  assign v_delta = abs_delta(old_y, new_y);

  // Checks are ordered by precedence; the first one that trips names the
  // reason, so e.g. an invalid black code moved by white reports BAD_PIECE.
  always_comb begin
    fail      = 1'b1;
    fail_code = OK;
    if ((old_x == new_x) && (old_y == new_y)) begin
      fail_code = NULL_MOVE;
    end else if (piece == PIECE_EMPTY) begin
      fail_code = EMPTY_SRC;
    end else if ((piece_kind(piece) == KIND_NONE) ||
                 (piece_kind(piece) == KIND_INVALID)) begin
      fail_code = BAD_PIECE;
    end else if (piece_color(piece) != side_to_move) begin
      fail_code = WRONG_SIDE;
    end else if ((dst != PIECE_EMPTY) &&
                 (piece_color(dst) == piece_color(piece))) begin
      fail_code = SELF_CAPTURE;
    end else begin
      fail = 1'b0;
    end
  end

endmodule

// File: rtl/move_dispatcher.sv
// Front-end stage of the board validator. Accepts one move request, runs
// the piece-independent pre-checks, starts the piece-specific shape checker
// and returns one registered legal/illegal verdict with a reason code.
// Parameters:
//   TIMEOUT_CYCLES  max WAIT cycles for chk_done before a TIMEOUT verdict
//   TCNT_W          timeout counter width, 2**TCNT_W > TIMEOUT_CYCLES
// Ports:
//   CLOCK_50, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_old_x/y, req_new_x/y    move coordinates, side_to_move colour
//   board_in                    piece codes [y][x], stable until response
//   chk_start                   one-cycle start pulse to the shape checker
//   chk_piece_type, chk_*_x/y   registered piece code and coordinates
//   chk_h_delta, chk_v_delta    registered absolute deltas
//   chk_done, chk_move_valid    checker completion and verdict
//   rsp_valid/rsp_ready         response handshake
//   rsp_legal, rsp_code         verdict and reason code
module move_dispatcher import chess_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TCNT_W         = 7
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_old_x,
  input  logic [2:0]           req_old_y,
  input  logic [2:0]           req_new_x,
  input  logic [2:0]           req_new_y,
  input  logic                 side_to_move,
  input  logic [7:0][7:0][3:0] board_in,
  output logic                 chk_start,
  output logic [3:0]           chk_piece_type,
  output logic [2:0]           chk_old_x,
  output logic [2:0]           chk_old_y,
  output logic [2:0]           chk_new_x,
  output logic [2:0]           chk_new_y,
  output logic [2:0]           chk_h_delta,
  output logic [2:0]           chk_v_delta,
  input  logic                 chk_done,
  input  logic                 chk_move_valid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_legal,
  output logic [2:0]           rsp_code
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  disp_state_t       state;
  logic [TCNT_W-1:0] tcnt;

  // Request fields captured at accept.
  logic [2:0]        old_x_p0;
  logic [2:0]        old_y_p0;
  logic [2:0]        new_x_p0;
  logic [2:0]        new_y_p0;
  logic              side_p0;

  logic [3:0]        pc_piece;
  logic [2:0]        pc_h_delta;
  logic [2:0]        pc_v_delta;
  logic              pc_fail;
  rsp_code_t         pc_code;

  move_precheck u_precheck (
    .board_in     (board_in),
    .old_x        (old_x_p0),
    .old_y        (old_y_p0),
    .new_x        (new_x_p0),
    .new_y        (new_y_p0),
    .side_to_move (side_p0),
    .piece        (pc_piece),
    .h_delta      (pc_h_delta),
    .v_delta      (pc_v_delta),
    .fail         (pc_fail),
    .fail_code    (pc_code)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      tcnt           <= '0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_legal      <= 1'b0;
      rsp_code       <= OK;
      chk_start      <= 1'b0;
      chk_piece_type <= '0;
      chk_old_x      <= '0;
      chk_old_y      <= '0;
      chk_new_x      <= '0;
      chk_new_y      <= '0;
      chk_h_delta    <= '0;
      chk_v_delta    <= '0;
      old_x_p0       <= '0;
      old_y_p0       <= '0;
      new_x_p0       <= '0;
      new_y_p0       <= '0;
      side_p0        <= 1'b0;
    end else begin
      chk_start <= 1'b0;
      case (state)
        // accept boundary: coordinates and side enter the _p0 registers
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            old_x_p0  <= req_old_x;
            old_y_p0  <= req_old_y;
            new_x_p0  <= req_new_x;
            new_y_p0  <= req_new_y;
            side_p0   <= side_to_move;
            req_ready <= 1'b0;
            state     <= ST_PRECHECK;
          end
        end

        // pre-check boundary: checker inputs are frozen until next accept
        ST_PRECHECK: begin
          chk_piece_type <= pc_piece;
          chk_old_x      <= old_x_p0;
          chk_old_y      <= old_y_p0;
          chk_new_x      <= new_x_p0;
          chk_new_y      <= new_y_p0;
          chk_h_delta    <= pc_h_delta;
          chk_v_delta    <= pc_v_delta;
          if (pc_fail) begin
            rsp_legal <= 1'b0;
            rsp_code  <= pc_code;
            state     <= ST_RESPOND;
          end else begin
            chk_start <= 1'b1;
            state     <= ST_DISPATCH;
          end
        end

        ST_DISPATCH: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end

        // checker boundary: chk_done takes priority over an expiring count
        ST_WAIT: begin
          if (chk_done) begin
            rsp_legal <= chk_move_valid;
            rsp_code  <= chk_move_valid ? OK : ILLEGAL_SHAPE;
            rsp_valid <= 1'b1;
            state     <= ST_RESPOND;
          end else if (tcnt == TCNT_LAST) begin
            rsp_legal <= 1'b0;
            rsp_code  <= TIMEOUT;
            rsp_valid <= 1'b1;
            state     <= ST_RESPOND;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        // response boundary: a pre-check rejection arrives here with
        // rsp_valid low and presents it one edge later, two edges after
        // accept; checker verdicts arrive with rsp_valid already set.
        ST_RESPOND: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
